pipeline_debug_ctrl: RTL

PIPELINE_DEBUG_CTRL -- requirements
Module: pipeline_debug_ctrl

---
 rtl/pipeline_debug_ctrl.sv | 264 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/pipeline_debug_ctrl.sv
// pipeline_debug_ctrl: byte-command debug controller for a pipelined core.
// Loads program words into the pipeline ('L'), runs until halt ('R'),
// single-steps ('S'), and after a halt or step dumps PC, the register
// file and the first DUMP_MEM data-memory words over a byte stream.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for a command byte
// PRST  | holding the pipeline in reset for two cycles before a load
// LOAD  | shifting in instruction bytes, MSB first
// WRITE | one-cycle write strobe with the assembled word
// RUN   | pipeline enabled until it reports halt
// STEP  | pipeline enabled for a single cycle
// DADDR | debug address presented; pipeline value captured at cycle end
// DSEND | streaming the captured word out one byte at a time
module pipeline_debug_ctrl #(
  parameter int INST_SZ  = 32,
  parameter int REG_SZ   = 5,
  parameter int DUMP_MEM = 32,
  parameter int MAX_INST = 256
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_pipe_reset,
  output logic               o_write,
  output logic               o_enable,
  output logic [INST_SZ-1:0] o_instruction,
  output logic [REG_SZ-1:0]  o_debug_addr,
  input  logic [INST_SZ-1:0] i_pc,
  input  logic [INST_SZ-1:0] i_reg,
  input  logic [INST_SZ-1:0] i_mem,
  input  logic               i_halt,
  output logic               o_busy
);

  localparam int BYTES  = INST_SZ / 8;
  localparam int BCNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int ITEM_W = $clog2(34 + DUMP_MEM);
  localparam int WCNT_W = $clog2(MAX_INST + 1);

  localparam logic [BCNT_W-1:0]  LAST_BYTE = BCNT_W'(BYTES - 1);
  localparam logic [ITEM_W-1:0]  FIRST_MEM = ITEM_W'(33);
  localparam logic [ITEM_W-1:0]  LAST_ITEM = ITEM_W'(32 + DUMP_MEM);
  localparam logic [WCNT_W-1:0]  MAX_CNT   = WCNT_W'(MAX_INST);
  localparam logic [INST_SZ-1:0] HALT_WORD = INST_SZ'(32'h0000_003F);

  localparam logic [7:0] CMD_LOAD = 8'h4C;
  localparam logic [7:0] CMD_RUN  = 8'h52;
  localparam logic [7:0] CMD_STEP = 8'h53;

  typedef enum logic [2:0] {
    IDLE, PRST, LOAD, WRITE, RUN, STEP, DADDR, DSEND
  } state_t;

  state_t               state_q, state_d;
  logic                 prst_q, prst_d;
  logic [BCNT_W-1:0]    byte_q, byte_d;
  logic [WCNT_W-1:0]    word_q, word_d;
  logic [ITEM_W-1:0]    item_q, item_d;
  logic [INST_SZ-9:0]   load_hi_q, load_hi_d;
  logic [INST_SZ-9:0]   tx_rest_q, tx_rest_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 tx_valid_q, tx_valid_d;
  logic                 write_q, write_d;
  logic                 enable_q, enable_d;
  logic                 pipe_reset_q, pipe_reset_d;
  logic [INST_SZ-1:0]   instr_q, instr_d;
  logic [REG_SZ-1:0]    debug_addr_q, debug_addr_d;
  logic [INST_SZ-1:0]   dump_word;
  logic                 start_dump;

  // Item 0 is the PC, items 1..32 are registers 0..31, the rest memory words.
  function automatic logic [REG_SZ-1:0] addr_of(input logic [ITEM_W-1:0] item);
    if (item == '0)
      return '0;
    else if (item < FIRST_MEM)
      return REG_SZ'(item - ITEM_W'(1));
    else
      return REG_SZ'(item - FIRST_MEM);
  endfunction

  // Select which pipeline view feeds the tx shift register for the current item.
  always_comb begin
    if (item_q == '0)
      dump_word = i_pc;
    else if (item_q < FIRST_MEM)
      dump_word = i_reg;
    else
      dump_word = i_mem;
  end

  // Next-state and next-output computation for the whole controller.
  always_comb begin
    state_d      = state_q;
    prst_d       = prst_q;
    byte_d       = byte_q;
    word_d       = word_q;
    item_d       = item_q;
    load_hi_d    = load_hi_q;
    tx_rest_d    = tx_rest_q;
    tx_data_d    = tx_data_q;
    tx_valid_d   = tx_valid_q;
    write_d      = 1'b0;
    enable_d     = enable_q;
    pipe_reset_d = pipe_reset_q;
    instr_d      = instr_q;
    debug_addr_d = debug_addr_q;
    start_dump   = 1'b0;

    case (state_q)
      IDLE: begin
        if (i_rx_valid) begin
          case (i_rx_data)
            CMD_LOAD: begin
              state_d      = PRST;
              pipe_reset_d = 1'b1;
              prst_d       = 1'b1;
            end
            CMD_RUN: begin
              if (i_halt) start_dump = 1'b1;
              else begin
                state_d  = RUN;
                enable_d = 1'b1;
              end
            end
            CMD_STEP: begin
              if (i_halt) start_dump = 1'b1;
              else begin
                state_d  = STEP;
                enable_d = 1'b1;
              end
            end
            default: ;
          endcase
        end
      end
      PRST: begin
        // Down-counter: pipeline reset spans this cycle and the next.
        if (prst_q != 1'b0) begin
          prst_d = prst_q - 1'b1;
        end else begin
          state_d      = LOAD;
          pipe_reset_d = 1'b0;
          byte_d       = '0;
          word_d       = '0;
        end
      end
      LOAD: begin
        if (i_rx_valid) begin
          if (byte_q == LAST_BYTE) begin
            instr_d = {load_hi_q, i_rx_data};
            write_d = 1'b1;
            byte_d  = '0;
            state_d = WRITE;
          end else begin
            load_hi_d = {load_hi_q[INST_SZ-17:0], i_rx_data};
            byte_d    = byte_q + BCNT_W'(1);
          end
        end
      end
      WRITE: begin
        word_d = word_q + WCNT_W'(1);
        if (instr_q == HALT_WORD || (word_q + WCNT_W'(1)) == MAX_CNT)
          state_d = IDLE;
        else
          state_d = LOAD;
      end
      RUN: begin
        if (i_halt) begin
          enable_d   = 1'b0;
          start_dump = 1'b1;
        end
      end
      STEP: begin
        enable_d   = 1'b0;
        start_dump = 1'b1;
      end
      DADDR: begin
        tx_data_d  = dump_word[INST_SZ-1 -: 8];
        tx_rest_d  = dump_word[INST_SZ-9:0];
        tx_valid_d = 1'b1;
        byte_d     = '0;
        state_d    = DSEND;
      end
      DSEND: begin
        if (i_tx_ready) begin
          if (byte_q == LAST_BYTE) begin
            tx_valid_d = 1'b0;
            byte_d     = '0;
            if (item_q == LAST_ITEM) begin
              state_d = IDLE;
            end else begin
              item_d       = item_q + ITEM_W'(1);
              debug_addr_d = addr_of(item_q + ITEM_W'(1));
              state_d      = DADDR;
            end
          end else begin
            tx_data_d = tx_rest_q[INST_SZ-9 -: 8];
            tx_rest_d = {tx_rest_q[INST_SZ-17:0], 8'h00};
            byte_d    = byte_q + BCNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (start_dump) begin
      state_d      = DADDR;
      item_d       = '0;
      debug_addr_d = '0;
      byte_d       = '0;
    end
  end

  // Controller state and registered outputs; reset aborts any operation.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      prst_q       <= 1'b0;
      byte_q       <= '0;
      word_q       <= '0;
      item_q       <= '0;
      load_hi_q    <= '0;
      tx_rest_q    <= '0;
      tx_data_q    <= '0;
      tx_valid_q   <= 1'b0;
      write_q      <= 1'b0;
      enable_q     <= 1'b0;
      pipe_reset_q <= 1'b0;
      instr_q      <= '0;
      debug_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      prst_q       <= prst_d;
      byte_q       <= byte_d;
      word_q       <= word_d;
      item_q       <= item_d;
      load_hi_q    <= load_hi_d;
      tx_rest_q    <= tx_rest_d;
      tx_data_q    <= tx_data_d;
      tx_valid_q   <= tx_valid_d;
      write_q      <= write_d;
      enable_q     <= enable_d;
      pipe_reset_q <= pipe_reset_d;
      instr_q      <= instr_d;
      debug_addr_q <= debug_addr_d;
    end
  end

  assign o_tx_data     = tx_data_q;
  assign o_tx_valid    = tx_valid_q;
  assign o_pipe_reset  = pipe_reset_q;
  assign o_write       = write_q;
  assign o_enable      = enable_q;
  assign o_instruction = instr_q;
  assign o_debug_addr  = debug_addr_q;
  assign o_busy        = (state_q != IDLE);

endmodule
